// File: rtl/dq_burst_converter.sv
// Serializes a full-burst write word onto the DQ pins and assembles serial read beats into a burst word.
// Optional BURST_CHOP_EN macro adds the bc4 input for 4-beat chopped bursts.
module dq_burst_converter #(
   parameter int DQ_BITS       = 16,
   parameter int BURST_LEN     = 8,
   parameter int WRITE_LATENCY = 4,
   parameter int READ_LATENCY  = 6
) (
   input  logic                         clk1,
   input  logic                         rst,
   input  logic                         wr_start,
   input  logic [BURST_LEN*DQ_BITS-1:0] wr_data,
   input  logic                         rd_start,
`ifdef BURST_CHOP_EN
   input  logic                         bc4,
`endif
   output logic                         busy,
   output logic [DQ_BITS-1:0]           dq_out,
   output logic                         dq_oe,
   input  logic [DQ_BITS-1:0]           dq_in,
   output logic [BURST_LEN*DQ_BITS-1:0] rd_data,
   output logic                         rd_data_valid,
   output logic                         protocol_err
);

   localparam int W    = BURST_LEN * DQ_BITS;
   localparam int MAXL = (WRITE_LATENCY > READ_LATENCY) ? WRITE_LATENCY : READ_LATENCY;
   localparam int CW   = $clog2(MAXL + BURST_LEN);

   typedef enum logic [2:0] {IDLE, WR_WAIT, WR_BURST, RD_WAIT, RD_BURST} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           chop_q, chop_d;
   logic [W-1:0]   wrBuf_q, wrBuf_d;
   logic [W-1:0]   rdShift_q, rdShift_d;
   logic [W-1:0]   rdData_q, rdData_d;
   logic [DQ_BITS-1:0] dqOut_q, dqOut_d;
   logic           dqOe_q, busy_q, rdValid_q, rdValid_d, err_q, err_d;
   logic           chopIn;

`ifdef BURST_CHOP_EN
   assign chopIn = bc4;
`else
   assign chopIn = 1'b0;
`endif

   function automatic logic [CW-1:0] lastBeat(input logic chop);
      return chop ? CW'(3) : CW'(BURST_LEN - 1);
   endfunction

   // Next-state logic; outputs are registered from the next state so that beat 0
   // appears exactly WRITE_LATENCY cycles after the accepting edge.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      chop_d    = chop_q;
      wrBuf_d   = wrBuf_q;
      rdShift_d = rdShift_q;
      rdData_d  = rdData_q;
      rdValid_d = 1'b0;
      err_d     = 1'b0;
      dqOut_d   = '0;
      case (state_q)
         IDLE: begin
            if (wr_start) begin
               err_d   = rd_start;
               wrBuf_d = wr_data;
               chop_d  = chopIn;
               if (WRITE_LATENCY > 1) begin
                  state_d = WR_WAIT;
                  cnt_d   = CW'(WRITE_LATENCY - 2);
               end else begin
                  state_d = WR_BURST;
                  cnt_d   = lastBeat(chopIn);
               end
            end else if (rd_start) begin
               rdShift_d = '0;
               chop_d    = chopIn;
               if (READ_LATENCY > 1) begin
                  state_d = RD_WAIT;
                  cnt_d   = CW'(READ_LATENCY - 2);
               end else begin
                  state_d = RD_BURST;
                  cnt_d   = lastBeat(chopIn);
               end
            end
         end
         WR_WAIT: begin
            if (cnt_q == '0) begin
               state_d = WR_BURST;
               cnt_d   = lastBeat(chop_q);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WR_BURST: begin
            if (cnt_q == '0) state_d = IDLE;
            else cnt_d = cnt_q - 1'b1;
         end
         RD_WAIT: begin
            if (cnt_q == '0) begin
               state_d = RD_BURST;
               cnt_d   = lastBeat(chop_q);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RD_BURST: begin
            rdShift_d = {dq_in, rdShift_q[W-1:DQ_BITS]};
            if (cnt_q == '0) begin
               state_d   = IDLE;
               rdValid_d = 1'b1;
               // A chopped burst lands in the top four words; shift it down so the upper words read as zero.
               rdData_d  = chop_q ? (rdShift_d >> ((BURST_LEN - 4) * DQ_BITS)) : rdShift_d;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if ((state_q != IDLE) && (wr_start || rd_start)) err_d = 1'b1;
      if (state_d == WR_BURST) begin
         dqOut_d = wrBuf_d[DQ_BITS-1:0];
         wrBuf_d = wrBuf_d >> DQ_BITS;
      end
   end

   // State and registered outputs; reset discards any partial burst.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         chop_q    <= 1'b0;
         wrBuf_q   <= '0;
         rdShift_q <= '0;
         rdData_q  <= '0;
         dqOut_q   <= '0;
         dqOe_q    <= 1'b0;
         busy_q    <= 1'b0;
         rdValid_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         chop_q    <= chop_d;
         wrBuf_q   <= wrBuf_d;
         rdShift_q <= rdShift_d;
         rdData_q  <= rdData_d;
         dqOut_q   <= dqOut_d;
         dqOe_q    <= (state_d == WR_BURST);
         busy_q    <= (state_d != IDLE);
         rdValid_q <= rdValid_d;
         err_q     <= err_d;
      end
   end

   assign busy          = busy_q;
   assign dq_out        = dqOut_q;
   assign dq_oe         = dqOe_q;
   assign rd_data       = rdData_q;
   assign rd_data_valid = rdValid_q;
   assign protocol_err  = err_q;

endmodule

// File: doc/dq_burst_converter.md
# dq_burst_converter

Data-path stage directly downstream of the command scheduler, between it and the PHY DQ pins. Converts one full-burst write word (BURST_LEN × DQ_BITS) into BURST_LEN serial DQ beats after the write latency. Collects BURST_LEN serial read beats after the read latency into one full-burst read word. One burst in flight at a time; the scheduler issues a start strobe only when `busy` is low.

## Interface
- DQ_BITS, 16, DQ pin width per beat
- BURST_LEN, 8, beats per burst (power of two, ≥4)
- WRITE_LATENCY, 4, cycles from accepted write start to beat 0 on `dq_out` (≥1)
- READ_LATENCY, 6, cycles from accepted read start to beat 0 sampled on `dq_in` (≥1)

Ports:
- clk1  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_start  in  1  single-cycle write-burst request
- wr_data  in  BURST_LEN*DQ_BITS  write word; sampled only in the cycle `wr_start` is accepted
- rd_start  in  1  single-cycle read-burst request
- busy  out  1  burst in flight; starts are not accepted
- dq_out  out  DQ_BITS  serialized write beat
- dq_oe  out  1  DQ output enable, high exactly during write beats
- dq_in  in  DQ_BITS  read beat from PHY
- rd_data  out  BURST_LEN*DQ_BITS  assembled read word
- rd_data_valid  out  1  one-cycle strobe qualifying `rd_data`
- protocol_err  out  1  one-cycle strobe on an illegal start

## Operation
- FSM states: IDLE, WR_WAIT, WR_BURST, RD_WAIT, RD_BURST. All outputs are registered.
- IDLE:
  - `wr_start` → latch `wr_data`, go to WR_WAIT.
  - `rd_start` → go to RD_WAIT.
- WR_WAIT counts WRITE_LATENCY−1 cycles, then goes to WR_BURST.
- WR_BURST drives beat k = `wr_data[k*DQ_BITS +: DQ_BITS]`, LSB beat first, with `dq_oe` = 1, for k = 0..BURST_LEN−1. After beat BURST_LEN−1 it returns to IDLE.
- RD_WAIT/RD_BURST behave the same way. Beat k from `dq_in` is stored into `rd_data[k*DQ_BITS +: DQ_BITS]`. After the last beat, `rd_data_valid` pulses and the FSM returns to IDLE.
- Single down-counter shared by wait and burst phases. Width = clog2(max(WRITE_LATENCY, READ_LATENCY) + BURST_LEN). No wrap: the counter is reloaded on every phase entry.
- `wr_start` and `rd_start` together in IDLE: the write is accepted, the read is dropped, `protocol_err` pulses.
- Any start while `busy` = 1: ignored, `protocol_err` pulses. The in-flight burst is unaffected.
- `rd_data` holds its value until the next read completes. `dq_out` returns to 0 when `dq_oe` is low.
- Reset (including mid-burst) asynchronously forces IDLE and sets every output to 0: `busy`, `dq_out`, `dq_oe`, `rd_data`, `rd_data_valid`, `protocol_err`. A partial read is discarded.

## Timing
- Write start accepted in cycle T:
  - `busy` = 1 from T+1.
  - `dq_oe` = 1 in cycles T+WRITE_LATENCY … T+WRITE_LATENCY+BURST_LEN−1, carrying beat k in cycle T+WRITE_LATENCY+k.
  - `busy` = 0 in cycle T+WRITE_LATENCY+BURST_LEN.
- Read start accepted in cycle T:
  - Beat k is sampled at the end of cycle T+READ_LATENCY+k.
  - `rd_data_valid` = 1 and `busy` = 0 in cycle T+READ_LATENCY+BURST_LEN.
- Back-to-back: a start presented in the first cycle with `busy` = 0 is accepted. Minimum start-to-start spacing is latency+BURST_LEN cycles.
- `protocol_err` asserts in the cycle after the offending start.

## Configuration
- `BURST_CHOP_EN` defined:
  - Adds input `bc4` (1 bit), sampled with the accepted start.
  - When `bc4` = 1, the burst is 4 beats: writes drive beats 0–3 only; reads fill beats 0–3 and zero the upper words of `rd_data`.
  - Busy/valid timing uses 4 in place of BURST_LEN.
- `BURST_CHOP_EN` undefined: no `bc4` port; every burst is BURST_LEN beats.

## Test plan
All scenarios use defaults unless noted.
- Write: `wr_start` at cycle 10 with `wr_data` = 0x7777_6666_5555_4444_3333_2222_1111_0000 → `dq_oe` high cycles 14–21; `dq_out` = 0x0000, 0x1111, … 0x7777; `busy` low at cycle 22.
- Read: `rd_start` at cycle 10, `dq_in` = 0xA000+k in cycle 16+k → `rd_data_valid` at cycle 24 with `rd_data` = 0xA007_A006_…_A000; `busy` low at cycle 24.
- Back-to-back: `rd_start` at cycle 22 directly after the write above → accepted; `busy` never low for more than 1 cycle; no `protocol_err`.
- Collision: `wr_start` and `rd_start` together in IDLE → write executes; `protocol_err` = 1 for one cycle; no read completes. Extra `rd_start` mid-write → `protocol_err` pulse; write beats unchanged.
- Reset: assert `rst` during read beat 3 → all outputs 0 immediately. After release, a new read completes with correct data and no stale beats.
- `BURST_CHOP_EN` with `bc4` = 1 write → `dq_oe` high 4 cycles (14–17), `busy` low at cycle 18. `bc4` read → upper 64 bits of `rd_data` = 0.
